sha256_msg_sched: RTL and testbench

- Sequencer for the SHA-256 message-schedule datapath.
- Buffers one 512-bit block as 16 input words, then emits W[0..63] in order over a valid/ready stream.
- Computes W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16] with a 16-word sliding window; sigma0/sigma1 are built from fixed right-shift and rotate units.
- Sits between the block buffer and the compression-round engine of the hashing core.

---
 rtl/sha256_msg_sched.sv | 125 ++++++++++++
 tb/tb_sha256_msg_sched.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule sequencer: loads a 16-word block, then streams W[0..ROUNDS-1]
// using a 16-word sliding window over a valid/ready handshake.
module sha256_msg_sched #(
  parameter int unsigned ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_word,
  output logic [5:0]  w_idx,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StEmit = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [5:0] LastT = 6'(ROUNDS - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  t_q, t_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [31:0] new_word;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // Window slot k holds W[t+k]; the taps below are W[t+14], W[t+9], W[t+1], W[t].
  assign new_word = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    for (int i = 0; i < 16; i++) begin
      win_d[i] = win_q[i];
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          cnt_d   = 4'd0;
        end
      end
      StLoad: begin
        if (in_valid) begin
          win_d[cnt_q] = in_word;
          cnt_d        = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = StEmit;
            t_d     = 6'd0;
          end
        end
      end
      StEmit: begin
        if (w_ready) begin
          for (int i = 0; i < 15; i++) begin
            win_d[i] = win_q[i + 1];
          end
          win_d[15] = new_word;
          t_d       = t_q + 6'd1;
          if (t_q == LastT) begin
            state_d = StDone;
            t_d     = 6'd0;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides everything; window contents are left as-is.
    if (abort) begin
      state_d = StIdle;
      cnt_d   = 4'd0;
      t_d     = 6'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      t_q     <= 6'd0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= 32'd0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  assign in_ready = (state_q == StLoad);
  assign w_valid  = (state_q == StEmit);
  assign w_word   = win_q[0];
  assign w_idx    = t_q;
  assign busy     = (state_q == StLoad) || (state_q == StEmit);
  assign done     = (state_q == StDone);

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched: reference-model scoreboard on the W stream,
// a table of known schedule words, and hand sequences for backpressure, abort and reset.
module tb_sha256_msg_sched;

  logic        clk = 1'b0;
  logic        rst, start, abort, in_valid, w_ready;
  logic [31:0] in_word;
  logic        in_ready, w_valid, busy, done;
  logic [31:0] w_word;
  logic [5:0]  w_idx;

  sha256_msg_sched #(.ROUNDS(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_word  (in_word),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_word   (w_word),
    .w_idx    (w_idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] w;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    string       name;
    int          blk;
    int          idx;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[9];

  logic [31:0] cap[64];
  logic [31:0] ref_abc[64];
  logic [31:0] abc[16];
  logic [31:0] ones[16];
  bit          mon_en      = 1'b0;
  bit          expect_done = 1'b0;
  bit          rnd_ready   = 1'b0;
  bit          stall_prev  = 1'b0;
  logic [31:0] prev_w;
  logic [5:0]  prev_idx;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h expected=%08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic push_model(input logic [31:0] blk[16]);
    logic [31:0] w[64];
    exp_t e;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = blk[t];
      else w[t] = s1(w[t-2]) + w[t-7] + s0(w[t-15]) + w[t-16];
      e.idx = 6'(t);
      e.w   = w[t];
      sb.push_back(e);
    end
  endtask

  // Downstream ready: always 1, or random when backpressure is requested.
  initial begin
    w_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      w_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      exp_t e;
      if (expect_done) begin
        check("done_pulse", 32'(done), 32'd1);
        expect_done = 1'b0;
      end else if (done) begin
        check("spurious_done", 32'(done), 32'd0);
      end
      if (stall_prev) begin
        check("stall_word", w_word, prev_w);
        check("stall_idx", 32'(w_idx), 32'(prev_idx));
      end
      stall_prev = w_valid && !w_ready;
      prev_w     = w_word;
      prev_idx   = w_idx;
      if (w_valid && w_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word got idx=%0d word=%08h expected none", w_idx, w_word);
        end else begin
          e = sb.pop_front();
          check("w_idx", 32'(w_idx), 32'(e.idx));
          check("w_word", w_word, e.w);
          cap[w_idx] = w_word;
          if (w_idx == 6'd63) expect_done = 1'b1;
        end
      end
    end
  end

  task automatic quiet_monitor();
    mon_en      = 1'b0;
    stall_prev  = 1'b0;
    expect_done = 1'b0;
    sb.delete();
  endtask

  // Loads blk (gap idle cycles between words) and drains the stream. abort_at >= 0 aborts
  // when that index is presented; start_in_done pulses start during the DONE cycle.
  task automatic run_block(input logic [31:0] blk[16], input int gap, input bit poke_start,
                           input int abort_at, input bit start_in_done);
    int n;
    for (int i = 0; i < 64; i++) cap[i] = 32'hdead_beef;
    push_model(blk);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("in_ready_load", 32'(in_ready), 32'd1);
    check("busy_load", 32'(busy), 32'd1);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_word  = blk[i];
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (i < 15) begin
        for (int g = 0; g < gap; g++) begin
          if (poke_start && g == 0 && i == 5) start = 1'b1;
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
    end
    check("emit_start_valid", 32'(w_valid), 32'd1);
    check("emit_start_idx", 32'(w_idx), 32'd0);
    check("in_ready_emit", 32'(in_ready), 32'd0);
    if (gap > 0) begin
      in_valid = 1'b1;
      in_word  = 32'hcafe_f00d;
      @(negedge clk);
      check("extra_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    n = 0;
    while (busy && n < 1000) begin
      if (abort_at >= 0 && w_valid && w_idx == 6'(abort_at)) begin
        quiet_monitor();
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
          check("abort_w_valid", 32'(w_valid), 32'd0);
          check("abort_busy", 32'(busy), 32'd0);
          check("abort_in_ready", 32'(in_ready), 32'd0);
          check("abort_done", 32'(done), 32'd0);
          @(posedge clk); #1;
        end
        mon_en = 1'b1;
        return;
      end
      @(posedge clk); #1;
      n++;
    end
    check("block_timeout", 32'(n < 1000), 32'd1);
    if (start_in_done) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_in_done_ready", 32'(in_ready), 32'd0);
      check("start_in_done_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      check("start_in_done_ready2", 32'(in_ready), 32'd0);
    end else begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic apply_table(input int blk);
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].blk == blk) check(tbl[i].name, cap[tbl[i].idx], tbl[i].exp);
    end
  endtask

  initial begin
    int mism;
    tbl[0] = '{"abc_w0",   0, 0,  32'h6162_6380};
    tbl[1] = '{"abc_w1",   0, 1,  32'h0000_0000};
    tbl[2] = '{"abc_w15",  0, 15, 32'h0000_0018};
    tbl[3] = '{"abc_w16",  0, 16, 32'h6162_6380};
    tbl[4] = '{"abc_w17",  0, 17, 32'h000F_0000};
    tbl[5] = '{"abc_w18",  0, 18, 32'h7DA8_6405};
    tbl[6] = '{"ones_w0",  1, 0,  32'hFFFF_FFFF};
    tbl[7] = '{"ones_w15", 1, 15, 32'hFFFF_FFFF};
    tbl[8] = '{"ones_w16", 1, 16, 32'h203F_FFFC};
    for (int i = 0; i < 16; i++) begin
      abc[i]  = 32'h0;
      ones[i] = 32'hFFFF_FFFF;
    end
    abc[0]  = 32'h6162_6380;
    abc[15] = 32'h0000_0018;

    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_word = 32'h0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_w_valid", 32'(w_valid), 32'd0);
    check("rst_w_word", w_word, 32'd0);
    check("rst_w_idx", 32'(w_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    mon_en = 1'b1;

    // Plain "abc" block at full rate.
    run_block(abc, 0, 1'b0, -1, 1'b0);
    apply_table(0);
    for (int i = 0; i < 64; i++) ref_abc[i] = cap[i];

    // All-ones block exercises modular wrap.
    run_block(ones, 0, 1'b0, -1, 1'b0);
    apply_table(1);

    // Random backpressure must reproduce the same stream.
    rnd_ready = 1'b1;
    run_block(abc, 0, 1'b0, -1, 1'b0);
    rnd_ready = 1'b0;
    mism = 0;
    for (int i = 0; i < 64; i++) if (cap[i] !== ref_abc[i]) mism++;
    check("backpressure_stream", 32'(mism), 32'd0);

    // Gapped input plus a stray start while busy.
    run_block(abc, 2, 1'b1, -1, 1'b0);
    apply_table(0);

    // Abort at t=20, then a clean reload.
    run_block(abc, 0, 1'b0, 20, 1'b0);
    run_block(abc, 0, 1'b0, -1, 1'b0);
    apply_table(0);

    // Asynchronous reset mid-LOAD after 7 words.
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_word  = abc[i] ^ 32'h5555_0000;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    quiet_monitor();
    #2 rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_w_valid", 32'(w_valid), 32'd0);
    check("midrst_w_word", w_word, 32'd0);
    check("midrst_w_idx", 32'(w_idx), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    mon_en = 1'b1;

    // Fresh block after reset; start pulsed during DONE must be ignored.
    run_block(abc, 0, 1'b0, -1, 1'b1);
    apply_table(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
